// File: rtl/bus68k_arbiter_if.sv
// 68k-style shared bus bundle used between requesters, arbiter and slave.
// master drives the cycle; slave answers with bus_ack/data_in.
interface bus68k;
    logic [23:0] addr;
    logic [15:0] data_out;
    logic        write_strobe;
    logic        as;
    logic        lds;
    logic        uds;
    logic        bus_ack;
    logic [15:0] data_in;

    modport master (
        output addr, data_out, write_strobe, as, lds, uds,
        input  bus_ack, data_in
    );

    modport slave (
        input  addr, data_out, write_strobe, as, lds, uds,
        output bus_ack, data_in
    );
endinterface

// File: rtl/bus68k_arbiter.sv
// Two-master arbiter for a shared 68k-style slave (CPU + DMA/video).
// Optional slave-ack watchdog: define BUS68K_ARBITER_TIMEOUT_EN.
module bus68k_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter bit FAIR           = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    bus68k.slave       m0,
    bus68k.slave       m1,
    bus68k.master      s,
    output logic [1:0] grant,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN0    = 2'd1,
        OWN1    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t state;
    logic   last;
    logic   forced;
    logic   owner_as;

    assign owner_as = (state == OWN0) ? m0.as :
                      (state == OWN1) ? m1.as : 1'b0;

    // Ownership FSM; grant and last-served pointer are registered with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            grant <= 2'b00;
            last  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (m0.as && (!m1.as || !FAIR || last)) begin
                        state <= OWN0;
                        grant <= 2'b01;
                        last  <= 1'b0;
                    end else if (m1.as) begin
                        state <= OWN1;
                        grant <= 2'b10;
                        last  <= 1'b1;
                    end
                end
                OWN0: begin
                    if (!m0.as) begin
                        state <= RELEASE;
                        grant <= 2'b00;
                    end
                end
                OWN1: begin
                    if (!m1.as) begin
                        state <= RELEASE;
                        grant <= 2'b00;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

`ifdef BUS68K_ARBITER_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wd_cnt;

    // Watchdog: counts unacked owner cycles, then fakes an ack until as drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt      <= '0;
            forced      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            if (owner_as) begin
                if (!forced) begin
                    if (s.bus_ack) begin
                        wd_cnt <= '0;
                    end else if (wd_cnt == LIMIT) begin
                        wd_cnt      <= '0;
                        forced      <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
            end else begin
                wd_cnt <= '0;
                forced <= 1'b0;
            end
        end
    end
`else
    // TIMEOUT_CYCLES only matters when the watchdog is built in.
    logic [31:0] unused_tmo;
    logic        unused_own;
    assign unused_tmo  = 32'(TIMEOUT_CYCLES);
    assign unused_own  = owner_as;
    assign forced      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Route the owner onto the slave and the slave's answer back to it.
    always_comb begin
        s.addr         = 24'h0;
        s.data_out     = 16'h0;
        s.write_strobe = 1'b0;
        s.as           = 1'b0;
        s.lds          = 1'b0;
        s.uds          = 1'b0;
        m0.bus_ack     = 1'b0;
        m0.data_in     = 16'h0;
        m1.bus_ack     = 1'b0;
        m1.data_in     = 16'h0;
        unique case (state)
            OWN0: begin
                s.addr         = m0.addr;
                s.data_out     = m0.data_out;
                s.write_strobe = m0.write_strobe;
                s.as           = m0.as;
                s.lds          = m0.lds;
                s.uds          = m0.uds;
                m0.bus_ack     = forced ? 1'b1 : s.bus_ack;
                m0.data_in     = forced ? 16'hFFFF : s.data_in;
            end
            OWN1: begin
                s.addr         = m1.addr;
                s.data_out     = m1.data_out;
                s.write_strobe = m1.write_strobe;
                s.as           = m1.as;
                s.lds          = m1.lds;
                s.uds          = m1.uds;
                m1.bus_ack     = forced ? 1'b1 : s.bus_ack;
                m1.data_in     = forced ? 16'hFFFF : s.data_in;
            end
            default: begin
            end
        endcase
    end

endmodule
